// File: rtl/level_quant_pkg.sv
// Shared level-quantizer constants: code widths, float32 reconstruction values and bin thresholds.
// Used by both the float-to-level quantizer and the level-to-float dequantizer.
package level_quant_pkg;

  localparam int NUM_LEVELS = 10;
  localparam int LEVEL_W    = 4;
  localparam int FLOAT_W    = 32;

  localparam logic [FLOAT_W-1:0] QNAN = 32'h7FC0_0000;

  // Bin midpoints; the two edge bins reconstruct to exactly +/-1.0.
  localparam logic [FLOAT_W-1:0] RECON [NUM_LEVELS] = '{
    32'h3F80_0000,   //  1.0
    32'h3F47_1C72,   //  7/9
    32'h3F0E_38E4,   //  5/9
    32'h3EAA_AAAB,   //  1/3
    32'h3DE3_8E39,   //  1/9
    32'hBDE3_8E39,   // -1/9
    32'hBEAA_AAAB,   // -1/3
    32'hBF0E_38E4,   // -5/9
    32'hBF47_1C72,   // -7/9
    32'hBF80_0000    // -1.0
  };

  // Bin boundaries, descending: level k covers (THRESH[k], THRESH[k-1]].
  localparam logic [FLOAT_W-1:0] THRESH [NUM_LEVELS-1] = '{
    32'h3F63_8E39,   //  8/9
    32'h3F2A_AAAB,   //  2/3
    32'h3EE3_8E39,   //  4/9
    32'h3E63_8E39,   //  2/9
    32'h0000_0000,   //  0
    32'hBE63_8E39,   // -2/9
    32'hBEE3_8E39,   // -4/9
    32'hBF2A_AAAB,   // -2/3
    32'hBF63_8E39    // -8/9
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } deq_state_e;

endpackage

// File: rtl/level_to_float_lut.sv
// Maps one 4-bit level code to its float32 reconstruction value; codes 10..15 give qNaN and raise illegal.
// Purely combinational, no backpressure.
module level_to_float_lut
  import level_quant_pkg::*;
(
  input  logic [LEVEL_W-1:0] code,
  output logic [FLOAT_W-1:0] value,
  output logic               illegal
);

  always_comb begin
    value   = QNAN;
    illegal = 1'b1;
    if (code < LEVEL_W'(NUM_LEVELS)) begin
      value   = RECON[code];
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/level_dequantizer.sv
// Unpacks a word of LANES level codes into one float32 per cycle; lane 0 appears 1 cycle after accept.
// Outputs hold during out_ready stalls; a new word is taken only in IDLE or on the final-lane handshake.
module level_dequantizer
  import level_quant_pkg::*;
#(
  parameter int LANES = 8,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LEVEL_W*LANES-1:0] in_levels,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FLOAT_W-1:0]       out_value,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_last,
  output logic                     code_err,
  output logic                     err_sticky,
  input  logic                     err_clr
);

  deq_state_e                 state_q, state_d;
  logic [LEVEL_W*LANES-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [FLOAT_W-1:0]         value_q, value_d;
  logic                       last_q, last_d;
  logic                       err_q, err_d;
  logic                       sticky_q, sticky_d;

  logic                       out_hs;
  logic                       load;
  logic [IDX_W-1:0]           next_idx;
  logic [LEVEL_W-1:0]         lut_code;
  logic [FLOAT_W-1:0]         lut_value;
  logic                       lut_illegal;

  assign out_valid  = (state_q == ST_EMIT);
  assign out_hs     = out_valid && out_ready;
  // Refill is allowed in the same cycle the final lane leaves, so back-to-back words have no bubble.
  assign in_ready   = (state_q == ST_IDLE) || (out_hs && last_q);
  assign load       = in_valid && in_ready;
  assign next_idx   = idx_q + IDX_W'(1);
  assign lut_code   = load ? in_levels[LEVEL_W-1:0] : hold_q[next_idx*LEVEL_W +: LEVEL_W];

  assign out_value  = value_q;
  assign out_index  = idx_q;
  assign out_last   = last_q;
  assign code_err   = err_q;
  assign err_sticky = sticky_q;

  level_to_float_lut u_lut (
    .code    (lut_code),
    .value   (lut_value),
    .illegal (lut_illegal)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    value_d = value_q;
    last_d  = last_q;
    err_d   = err_q;

    if (load) begin
      state_d = ST_EMIT;
      hold_d  = in_levels;
      idx_d   = '0;
      value_d = lut_value;
      err_d   = lut_illegal;
      last_d  = 1'b0;
    end else if (out_hs) begin
      if (last_q) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        value_d = '0;
        err_d   = 1'b0;
        last_d  = 1'b0;
      end else begin
        idx_d   = next_idx;
        value_d = lut_value;
        err_d   = lut_illegal;
        last_d  = (next_idx == IDX_W'(LANES - 1));
      end
    end

    // A new error outranks a simultaneous clear.
    sticky_d = (sticky_q && !err_clr) || (out_hs && err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      idx_q    <= '0;
      value_q  <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      value_q  <= value_d;
      last_q   <= last_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_level_dequantizer.sv
// Scoreboard bench for level_dequantizer: accepted words expand into expected lanes, a monitor pops and compares.
module tb_level_dequantizer;

  localparam int LANES = 8;
  localparam int IDX_W = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [4*LANES-1:0] in_levels;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_value;
  logic [IDX_W-1:0]   out_index;
  logic               out_last;
  logic               code_err;
  logic               err_sticky;
  logic               err_clr;

  logic               in_valid2;
  logic               in_ready2;
  logic [7:0]         in_levels2;
  logic               out_valid2;
  logic               out_ready2;
  logic [31:0]        out_value2;
  logic [0:0]         out_index2;
  logic               out_last2;
  logic               code_err2;
  logic               err_sticky2;
  logic               err_clr2;

  always #5 clk = ~clk;

  level_dequantizer #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_levels(in_levels),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_index(out_index), .out_last(out_last), .code_err(code_err),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  level_dequantizer #(.LANES(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_levels(in_levels2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_value(out_value2),
    .out_index(out_index2), .out_last(out_last2), .code_err(code_err2),
    .err_sticky(err_sticky2), .err_clr(err_clr2)
  );

  typedef struct {
    logic [31:0] value;
    int          index;
    bit          last;
    bit          err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   exp_sticky = 1'b0;
  int   rdy_mode = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: levels 0..4 step down from 1.0 by 2/9; levels 5..9 mirror them with the sign flipped.
  function automatic logic [31:0] recon(int k);
    logic [31:0] pos [5];
    pos = '{32'h3F800000, 32'h3F471C72, 32'h3F0E38E4, 32'h3EAAAAAB, 32'h3DE38E39};
    if (k > 9) return 32'h7FC00000;
    if (k >= 5) return {1'b1, pos[9-k][30:0]};
    return pos[k];
  endfunction

  // Monitor: checks every cycle, pops on output handshake, pushes a word's lanes on input handshake.
  logic [31:0]      stall_val;
  logic [IDX_W-1:0] stall_idx;
  bit               stall_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_sticky = 1'b0;
      stall_prev = 1'b0;
    end else begin
      bit   hs;
      bit   e_err;
      exp_t e;
      hs    = out_valid && out_ready;
      e_err = 1'b0;
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("in_ready", 32'(in_ready),
            32'((q.size() == 0) || (hs && q.size() > 0 && q[0].last)));
      check("err_sticky", 32'(err_sticky), 32'(exp_sticky));
      if (stall_prev) begin
        check("stall_value", out_value, stall_val);
        check("stall_index", 32'(out_index), 32'(stall_idx));
      end
      if (hs) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          e_err = e.err;
          check("out_value", out_value, e.value);
          check("out_index", 32'(out_index), 32'(e.index));
          check("out_last", 32'(out_last), 32'(e.last));
          check("code_err", 32'(code_err), 32'(e.err));
        end
      end
      exp_sticky = (hs && e_err) ? 1'b1 : (err_clr ? 1'b0 : exp_sticky);
      stall_prev = out_valid && !out_ready;
      stall_val  = out_value;
      stall_idx  = out_index;
      if (in_valid && in_ready) begin
        for (int i = 0; i < LANES; i++) begin
          int code;
          code    = int'(in_levels[4*i +: 4]);
          e.value = recon(code);
          e.index = i;
          e.last  = (i == LANES - 1);
          e.err   = (code > 9);
          q.push_back(e);
        end
      end
    end
  end

  // out_ready / err_clr shaping: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  initial begin
    int pc;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    pc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin out_ready = pat[pc % 4]; pc++; end
        2: begin
          out_ready = ($urandom_range(0, 3) != 0);
          err_clr   = ($urandom_range(0, 7) == 0);
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic send(logic [4*LANES-1:0] w);
    bit ok;
    ok = 1'b0;
    in_valid  = 1'b1;
    in_levels = w;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_levels = $urandom();
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("drain_timeout", 32'(0), 32'(1));
  endtask

  task automatic check_reset();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_value", out_value, 32'(0));
    check("rst_out_index", 32'(out_index), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    check("rst_code_err", 32'(code_err), 32'(0));
    check("rst_err_sticky", 32'(err_sticky), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_levels  = '0;
    err_clr    = 1'b0;
    in_valid2  = 1'b0;
    in_levels2 = '0;
    out_ready2 = 1'b1;
    err_clr2   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1;

    // Lanes 0..7 carry levels 0..7.
    send(32'h76543210);
    drain();

    // Back-to-back words, in_valid held high across the boundary.
    send(32'h89abcdef & 32'h88888888 | 32'h01234567);
    send(32'h13579024);
    drain();

    // Stall pattern on a word of 8s and 9s.
    rdy_mode = 1;
    send(32'h98989898);
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Illegal code 12 in lane 3 sets the sticky flag.
    send(32'h1111C111);
    drain();
    check("sticky_after_err", 32'(err_sticky), 32'(1));
    // Clear concurrent with fresh errors: set wins.
    @(posedge clk);
    #1;
    send(32'hFFFFFFFF);
    err_clr = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("sticky_set_wins", 32'(err_sticky), 32'(1));
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("sticky_cleared", 32'(err_sticky), 32'(0));

    // Reset mid-word at lane 4.
    @(posedge clk);
    #1;
    send(32'h43214321);
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid && out_index == 3'd4) begin found = 1'b1; break; end
    end
    check("reached_lane4", 32'(found), 32'(1));
    rst = 1'b1;
    #1;
    check_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(32'h90817263);
    drain();

    // Randomised words, gaps, stalls and clears.
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      send($urandom());
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    drain();

    // Two-lane build: word {9,0}.
    @(posedge clk);
    #1;
    in_valid2  = 1'b1;
    in_levels2 = 8'h90;
    @(negedge clk);
    check("l2_in_ready", 32'(in_ready2), 32'(1));
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    @(negedge clk);
    check("l2_valid0", 32'(out_valid2), 32'(1));
    check("l2_value0", out_value2, 32'h3F800000);
    check("l2_index0", 32'(out_index2), 32'(0));
    check("l2_last0", 32'(out_last2), 32'(0));
    @(negedge clk);
    check("l2_valid1", 32'(out_valid2), 32'(1));
    check("l2_value1", out_value2, 32'hBF800000);
    check("l2_index1", 32'(out_index2), 32'(1));
    check("l2_last1", 32'(out_last2), 32'(1));
    @(negedge clk);
    check("l2_idle", 32'(out_valid2), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
